// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU fetch/data ports, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req_valid;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic              i_resp_valid;
   logic [DATA_W-1:0] i_resp_data;

   logic              d_req_valid;
   logic              d_req_write;
   logic [ADDR_W-1:0] d_req_addr;
   logic [DATA_W-1:0] d_req_wdata;
   logic              d_req_ready;
   logic              d_resp_valid;
   logic [DATA_W-1:0] d_resp_data;

   logic              m_req_valid;
   logic              m_req_write;
   logic [ADDR_W-1:0] m_req_addr;
   logic [DATA_W-1:0] m_req_wdata;
   logic              m_req_ready;
   logic              m_resp_valid;
   logic [DATA_W-1:0] m_resp_data;

   modport slave (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_resp_valid, i_resp_data,
      input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
      output d_req_ready, d_resp_valid, d_resp_data,
      output m_req_valid, m_req_write, m_req_addr, m_req_wdata,
      input  m_req_ready, m_resp_valid, m_resp_data
   );

   modport master (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_resp_valid, i_resp_data,
      output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  m_req_valid, m_req_write, m_req_addr, m_req_wdata,
      output m_req_ready, m_resp_valid, m_resp_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Data has priority; a saturating counter forces a fetch grant after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | no transaction; grant evaluated combinationally
// REQ   | presenting latched request to memory, waiting for m_req_ready
// WAIT  | request accepted, waiting for m_resp_valid
// RESP  | one-cycle response pulse to the owning port
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_port_arbiter_if.slave     bus,
   output logic                  busy,
   output logic                  owner
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic              grant_i, grant_d;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_write;
   logic [DATA_W-1:0] resp_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            // Ready stays low while reset is held so every output reads 0 in reset.
            if (reset) begin
               grant_i = bus.i_req_valid && (!bus.d_req_valid || starve_cnt == CNT_MAX);
               grant_d = bus.d_req_valid && !grant_i;
            end
            if (grant_i || grant_d) state_nxt = REQ;
         end
         REQ:     if (bus.m_req_ready)  state_nxt = WAIT;
         WAIT:    if (bus.m_resp_valid) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
         owner      <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_write  <= 1'b0;
         resp_data  <= '0;
      end else begin
         if (grant_i || grant_d) begin
            lat_addr  <= grant_i ? bus.i_req_addr : bus.d_req_addr;
            lat_wdata <= grant_i ? '0 : bus.d_req_wdata;
            lat_write <= grant_d && bus.d_req_write;
            owner     <= grant_d;
         end
         if (grant_i)
            starve_cnt <= '0;
         else if (grant_d && bus.i_req_valid && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);
         if (state == WAIT && bus.m_resp_valid)
            resp_data <= lat_write ? '0 : bus.m_resp_data;
      end
   end

   assign bus.i_req_ready  = grant_i;
   assign bus.d_req_ready  = grant_d;

   assign bus.m_req_valid  = (state == REQ);
   assign bus.m_req_write  = lat_write;
   assign bus.m_req_addr   = lat_addr;
   assign bus.m_req_wdata  = lat_wdata;

   assign bus.i_resp_valid = (state == RESP) && !owner;
   assign bus.d_resp_valid = (state == RESP) && owner;
   assign bus.i_resp_data  = bus.i_resp_valid ? resp_data : '0;
   assign bus.d_resp_data  = bus.d_resp_valid ? resp_data : '0;

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/store timing, priority, starvation, spurious memory
// signals and mid-transaction reset, all against hand-computed expectations.
module tb_mem_port_arbiter;
   logic clk;
   logic reset;
   logic busy;
   logic owner;
   int   n_checks;
   int   n_errors;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy),
      .owner (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entered just after the grant edge (state REQ); returns just after the edge into RESP.
   task automatic serve(input int stall, input int lat, input logic [31:0] data);
      bus.m_req_ready = 1'b0;
      repeat (stall) cyc();
      bus.m_req_ready = 1'b1;
      cyc();
      bus.m_req_ready = 1'b0;
      repeat (lat) cyc();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = data;
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h40;
      bus.d_req_valid = 1'b0;  bus.d_req_write = 1'b0;
      bus.d_req_addr  = '0;    bus.d_req_wdata = '0;
      bus.m_req_ready = 1'b0;  bus.m_resp_valid = 1'b0;  bus.m_resp_data = '0;

      // Reset state, with a fetch already pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_owner", owner, 0);
      check_val("rst_i_ready", bus.i_req_ready, 0);
      check_val("rst_m_valid", bus.m_req_valid, 0);
      check_val("rst_m_addr", bus.m_req_addr, 0);
      check_val("rst_i_resp", bus.i_resp_valid, 0);

      // Fetch read: cycle 0 is the grant cycle right after reset release.
      cyc();
      reset = 1'b1;
      @(negedge clk);
      check_val("f_i_ready_c0", bus.i_req_ready, 1);
      check_val("f_d_ready_c0", bus.d_req_ready, 0);
      cyc();
      bus.i_req_valid = 1'b0;
      bus.m_req_ready = 1'b1;
      @(negedge clk);
      check_val("f_m_valid_c1", bus.m_req_valid, 1);
      check_val("f_m_addr_c1", bus.m_req_addr, 32'h40);
      check_val("f_m_write_c1", bus.m_req_write, 0);
      check_val("f_busy_c1", busy, 1);
      check_val("f_i_ready_c1", bus.i_req_ready, 0);
      cyc();
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h00A00093;
      @(negedge clk);
      check_val("f_m_valid_c2", bus.m_req_valid, 0);
      check_val("f_i_resp_c2", bus.i_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
      @(negedge clk);
      check_val("f_i_resp_c3", bus.i_resp_valid, 1);
      check_val("f_i_data_c3", bus.i_resp_data, 32'h00A00093);
      check_val("f_d_resp_c3", bus.d_resp_valid, 0);
      cyc();
      @(negedge clk);
      check_val("f_i_resp_c4", bus.i_resp_valid, 0);
      check_val("f_busy_c4", busy, 0);

      // Simultaneous requests: data first, fetch once data drops.
      cyc();
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h44;
      bus.d_req_valid = 1'b1;  bus.d_req_addr = 32'h1000;  bus.d_req_write = 1'b0;
      @(negedge clk);
      check_val("sim_d_ready", bus.d_req_ready, 1);
      check_val("sim_i_ready", bus.i_req_ready, 0);
      cyc();
      bus.d_req_valid = 1'b0;
      @(negedge clk);
      check_val("sim_cnt_1", dut.starve_cnt, 1);
      check_val("sim_owner_d", owner, 1);
      check_val("sim_m_addr_d", bus.m_req_addr, 32'h1000);
      serve(0, 0, 32'h11);
      @(negedge clk);
      check_val("sim_d_resp", bus.d_resp_valid, 1);
      check_val("sim_d_data", bus.d_resp_data, 32'h11);
      check_val("sim_i_resp_none", bus.i_resp_valid, 0);
      cyc();
      @(negedge clk);
      check_val("sim_i_ready2", bus.i_req_ready, 1);
      check_val("sim_d_ready2", bus.d_req_ready, 0);
      cyc();
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      check_val("sim_cnt_0", dut.starve_cnt, 0);
      check_val("sim_owner_i", owner, 0);
      serve(0, 0, 32'h22);
      @(negedge clk);
      check_val("sim_i_resp", bus.i_resp_valid, 1);
      check_val("sim_i_data", bus.i_resp_data, 32'h22);
      cyc();

      // Starvation: both held valid; expected grant order D D D D I D.
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h48;
      bus.d_req_valid = 1'b1;  bus.d_req_addr = 32'h2000;
      for (int g = 0; g < 6; g++) begin
         @(negedge clk);
         check_val($sformatf("stv_d_ready_%0d", g), bus.d_req_ready, (g != 4));
         check_val($sformatf("stv_i_ready_%0d", g), bus.i_req_ready, (g == 4));
         cyc();
         serve(0, 0, 32'h500 + g);
         @(negedge clk);
         check_val($sformatf("stv_d_resp_%0d", g), bus.d_resp_valid, (g != 4));
         check_val($sformatf("stv_i_resp_%0d", g), bus.i_resp_valid, (g == 4));
         if (g == 3) check_val("stv_cnt_sat", dut.starve_cnt, 4);
         if (g == 4) check_val("stv_cnt_clr", dut.starve_cnt, 0);
         cyc();
      end
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;

      // Store with three REQ stall cycles; payload changes after grant must not leak.
      bus.d_req_valid = 1'b1;  bus.d_req_write = 1'b1;
      bus.d_req_addr  = 32'h100;  bus.d_req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check_val("st_d_ready", bus.d_req_ready, 1);
      cyc();
      bus.d_req_valid = 1'b0;
      bus.d_req_addr  = 32'h555;
      bus.d_req_wdata = 32'h0;
      bus.d_req_write = 1'b0;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         check_val($sformatf("st_m_valid_%0d", s), bus.m_req_valid, 1);
         check_val($sformatf("st_m_addr_%0d", s), bus.m_req_addr, 32'h100);
         check_val($sformatf("st_m_wdata_%0d", s), bus.m_req_wdata, 32'hDEADBEEF);
         check_val($sformatf("st_m_write_%0d", s), bus.m_req_write, 1);
         check_val($sformatf("st_busy_%0d", s), busy, 1);
         bus.m_req_ready = (s == 3);
         cyc();
      end
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h12345678;
      @(negedge clk);
      check_val("st_wait_m_valid", bus.m_req_valid, 0);
      check_val("st_wait_d_resp", bus.d_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
      @(negedge clk);
      check_val("st_d_resp", bus.d_resp_valid, 1);
      check_val("st_d_data", bus.d_resp_data, 0);
      check_val("st_i_resp", bus.i_resp_valid, 0);
      cyc();
      @(negedge clk);
      check_val("st_d_resp_once", bus.d_resp_valid, 0);
      check_val("st_busy_idle", busy, 0);

      // Spurious m_resp_valid during REQ is ignored.
      cyc();
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h200;
      @(negedge clk);
      check_val("sp_i_ready", bus.i_req_ready, 1);
      cyc();
      bus.i_req_valid  = 1'b0;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'hBAD;
      @(negedge clk);
      check_val("sp_req_hold", bus.m_req_valid, 1);
      cyc();
      @(negedge clk);
      check_val("sp_req_hold2", bus.m_req_valid, 1);
      check_val("sp_no_resp", bus.i_resp_valid, 0);
      bus.m_req_ready = 1'b1;
      cyc();
      bus.m_req_ready  = 1'b0;
      bus.m_resp_valid = 1'b0;
      @(negedge clk);
      check_val("sp_wait_busy", busy, 1);
      check_val("sp_wait_no_resp", bus.i_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h600D;
      @(negedge clk);
      check_val("sp_wait2_no_resp", bus.i_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
      @(negedge clk);
      check_val("sp_i_resp", bus.i_resp_valid, 1);
      check_val("sp_i_data", bus.i_resp_data, 32'h600D);
      cyc();

      // Reset while in WAIT.
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h300;
      cyc();
      bus.i_req_valid = 1'b0;
      bus.m_req_ready = 1'b1;
      cyc();
      bus.m_req_ready = 1'b0;
      #2;
      check_val("rw_busy_pre", busy, 1);
      reset = 1'b0;
      #1;
      check_val("rw_busy_now", busy, 0);
      check_val("rw_m_valid", bus.m_req_valid, 0);
      check_val("rw_i_resp", bus.i_resp_valid, 0);
      cyc();
      reset = 1'b1;
      bus.m_resp_valid = 1'b1;
      bus.m_resp_data  = 32'h77;
      @(negedge clk);
      check_val("rw_late_i_resp", bus.i_resp_valid, 0);
      check_val("rw_late_d_resp", bus.d_resp_valid, 0);
      cyc();
      bus.m_resp_valid = 1'b0;
      bus.m_resp_data  = '0;
      @(negedge clk);
      check_val("rw_late_i_resp2", bus.i_resp_valid, 0);
      check_val("rw_late_busy", busy, 0);
      cyc();
      bus.i_req_valid = 1'b1;  bus.i_req_addr = 32'h80;
      @(negedge clk);
      check_val("rw_new_ready", bus.i_req_ready, 1);
      cyc();
      bus.i_req_valid = 1'b0;
      @(negedge clk);
      check_val("rw_new_addr", bus.m_req_addr, 32'h80);
      serve(1, 1, 32'h13);
      @(negedge clk);
      check_val("rw_new_resp", bus.i_resp_valid, 1);
      check_val("rw_new_data", bus.i_resp_data, 32'h13);
      cyc();
      @(negedge clk);
      check_val("rw_new_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
